// File: rtl/upg_loader_if.sv
// Programming-port bundle between the UART-side driver and upg_loader.
// Carries session control, the received byte strobe, and the memory write port.
// Port summary: start/abort/rx_* flow into the loader; upg_*/busy/err flow out.
interface upg_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic              start_i;
    logic              abort_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              upg_wen_o;
    logic [ADDR_W:0]   upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              busy_o;
    logic              err_o;

    // Driver side (UART receiver / session controller)
    modport master (
        output start_i, abort_i, rx_valid_i, rx_data_i,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
    );

    // Loader side
    modport slave (
        input  start_i, abort_i, rx_valid_i, rx_data_i,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
    );
endinterface

// File: rtl/upg_loader.sv
// Purpose: packs UART bytes into LE 32-bit words and writes imem then dmem via upg_*.
// Latency: write strobe in the cycle after the 4th byte of a word is received.
// Backpressure: none; every rx_valid byte is taken, including in the write cycle.
// Ports: clk/rst_n plain; bus (slave) carries start/abort/rx bytes in and the
// memory write port plus done/busy/err status out.
module upg_loader #(
    parameter int ADDR_W  = 14,
    parameter int WORDS   = 16384,
    parameter int TIMEOUT = 10000000,
    parameter int TO_W    = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    upg_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;     // lanes 0..2; lane 3 goes straight to dat
    logic              sel_q, sel_d;     // 0 = imem, 1 = dmem
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            asm_q   <= '0;
            sel_q   <= 1'b0;
            idx_q   <= '0;
            to_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        to_d    = to_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        done_d  = done_q;
        busy_d  = busy_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                // Bytes are ignored here, even alongside start_i.
                if (bus.start_i) begin
                    state_d = RECV;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    lane_d  = '0;
                    sel_d   = 1'b0;
                    idx_d   = '0;
                    to_d    = '0;
                end
            end
            RECV: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    lane_d  = '0;
                end else if (bus.rx_valid_i) begin
                    // A byte in the expiry cycle still counts as activity.
                    to_d = '0;
                    if (lane_q == 2'd3) begin
                        dat_d   = {bus.rx_data_i, asm_q};
                        adr_d   = {sel_q, idx_q};
                        lane_d  = '0;
                        state_d = WRITE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0:    asm_d[7:0]   = bus.rx_data_i;
                            2'd1:    asm_d[15:8]  = bus.rx_data_i;
                            default: asm_d[23:16] = bus.rx_data_i;
                        endcase
                    end
                end else if (to_q == TO_LAST) begin
                    // Partial word is dropped; nothing is written.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    lane_d  = '0;
                    to_d    = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WRITE: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    lane_d  = '0;
                end else begin
                    to_d    = '0;
                    state_d = RECV;
                    // The assembly register is free again, so a byte here
                    // becomes lane 0 of the next word.
                    if (bus.rx_valid_i) begin
                        asm_d[7:0] = bus.rx_data_i;
                        lane_d     = 2'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (sel_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            sel_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe is decoded from state so an abort can suppress it in the same cycle.
    assign bus.upg_wen_o  = (state_q == WRITE) && !bus.abort_i;
    assign bus.upg_adr_o  = adr_q;
    assign bus.upg_dat_o  = dat_q;
    assign bus.upg_done_o = done_q;
    assign bus.busy_o     = busy_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_upg_loader.sv
// Bench for upg_loader: directed scenarios with literal expectations plus a
// randomized byte/start/abort stream, all compared against a queue-based model.
// Summary line reports errors and total comparisons.
module tb_upg_loader;
    localparam int ADDR_W  = 14;
    localparam int WORDS   = 2;
    localparam int TIMEOUT = 16;
    localparam int AW1     = ADDR_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upg_loader_if #(.ADDR_W(ADDR_W)) bus ();

    upg_loader #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS),
        .TIMEOUT(TIMEOUT),
        .TO_W   (24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_active, m_in_write, m_done, m_err;
    logic [7:0]  m_bytes[$];
    int          m_n, m_idle;
    logic [ADDR_W:0] m_adr;
    logic [31:0] m_dat;

    initial begin
        logic s, a, v;
        logic [7:0] d;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_in_write = 0; m_done = 0; m_err = 0;
                m_bytes.delete(); m_n = 0; m_idle = 0; m_adr = '0; m_dat = '0;
            end else begin
                s = bus.start_i; a = bus.abort_i; v = bus.rx_valid_i; d = bus.rx_data_i;
                if (!m_active) begin
                    if (s) begin
                        m_active = 1; m_in_write = 0; m_bytes.delete();
                        m_n = 0; m_idle = 0; m_done = 0; m_err = 0;
                    end
                end else if (a) begin
                    m_active = 0; m_in_write = 0; m_err = 1; m_bytes.delete();
                end else if (m_in_write) begin
                    m_in_write = 0;
                    m_n++;
                    m_bytes.delete();
                    m_idle = 0;
                    if (v) m_bytes.push_back(d);
                    if (m_n == 2 * WORDS) begin
                        m_active = 0; m_done = 1;
                    end
                end else if (v) begin
                    m_bytes.push_back(d);
                    m_idle = 0;
                    if (m_bytes.size() == 4) begin
                        m_dat = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_adr = (m_n < WORDS) ? AW1'(m_n) : AW1'((1 << ADDR_W) + m_n - WORDS);
                        m_in_write = 1;
                        m_bytes.delete();
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_active = 0; m_err = 1; m_bytes.delete();
                    end
                end
            end
        end
    end

    // ---------------- compare + write log ----------------
    logic [ADDR_W+32:0] wlog[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("wen",  bus.upg_wen_o,  m_in_write && !bus.abort_i);
            chk("adr",  bus.upg_adr_o,  m_adr);
            chk("dat",  bus.upg_dat_o,  m_dat);
            chk("done", bus.upg_done_o, m_done);
            chk("busy", bus.busy_o,     m_active);
            chk("err",  bus.err_o,      m_err);
            if (bus.upg_wen_o) wlog.push_back({bus.upg_adr_o, bus.upg_dat_o});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic a, input logic v, input logic [7:0] d);
        bus.start_i    = s;
        bus.abort_i    = a;
        bus.rx_valid_i = v;
        bus.rx_data_i  = d;
        @(posedge clk);
        #1;
        bus.start_i    = 1'b0;
        bus.abort_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"},  bus.upg_wen_o,  1'b0);
        chk({tag, "_adr"},  bus.upg_adr_o,  '0);
        chk({tag, "_dat"},  bus.upg_dat_o,  '0);
        chk({tag, "_done"}, bus.upg_done_o, 1'b0);
        chk({tag, "_busy"}, bus.busy_o,     1'b0);
        chk({tag, "_err"},  bus.err_o,      1'b0);
    endtask

    logic [7:0] img1 [16] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] img2 [16];

    initial begin
        int r;
        bus.start_i    = 1'b0;
        bus.abort_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;

        // Reset state
        #1;
        chk_all_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full image with gaps between bytes
        wlog.delete();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send(img1[i]);
            idle(1);
        end
        idle(2);
        chk("t1_nwrites", wlog.size(), 4);
        chk("t1_w0", wlog[0], {15'h0000, 32'h12345678});
        chk("t1_w1", wlog[1], {15'h0001, 32'hDEADBEEF});
        chk("t1_w2", wlog[2], {15'h4000, 32'h04030201});
        chk("t1_w3", wlog[3], {15'h4001, 32'h08070605});
        chk("t1_done", bus.upg_done_o, 1'b1);
        chk("t1_busy", bus.busy_o, 1'b0);

        // Back-to-back bytes, including the write cycles
        for (int i = 0; i < 16; i++) img2[i] = 8'($urandom);
        wlog.delete();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) send(img2[i]);
        idle(2);
        chk("t2_nwrites", wlog.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("t2_word", wlog[k][31:0],
                {img2[4*k+3], img2[4*k+2], img2[4*k+1], img2[4*k]});
        chk("t2_done", bus.upg_done_o, 1'b1);

        // Timeout after 3 bytes
        wlog.delete();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'hA1); send(8'hA2); send(8'hA3);
        idle(TIMEOUT - 1);
        chk("t3_busy_before", bus.busy_o, 1'b1);
        idle(1);
        chk("t3_err", bus.err_o, 1'b1);
        chk("t3_busy", bus.busy_o, 1'b0);
        chk("t3_done", bus.upg_done_o, 1'b0);
        chk("t3_nwrites", wlog.size(), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_err_cleared", bus.err_o, 1'b0);
        chk("t3_busy_again", bus.busy_o, 1'b1);

        // Abort together with the 4th byte
        wlog.delete();
        send(8'h10); send(8'h20); send(8'h30);
        cyc(1'b0, 1'b1, 1'b1, 8'h40);
        chk("t4_err", bus.err_o, 1'b1);
        chk("t4_busy", bus.busy_o, 1'b0);
        idle(2);
        chk("t4_nwrites", wlog.size(), 0);

        // Byte alongside start is ignored
        wlog.delete();
        cyc(1'b1, 1'b0, 1'b1, 8'hAA);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(1);
        chk("t5_nwrites", wlog.size(), 1);
        chk("t5_w0", wlog[0], {15'h0000, 32'h44332211});
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-session
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wlog.delete();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
        idle(1);
        chk("t6_nwrites", wlog.size(), 1);
        chk("t6_w0", wlog[0], {15'h0000, 32'hD3D2D1D0});

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2)        cyc(1'b1, 1'b0, 1'b0, 8'h00);
            else if (r < 4)   cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (r < 6)   idle($urandom_range(TIMEOUT - 4, TIMEOUT + 2));
            else if (r < 10)  cyc(1'b1, 1'b0, 1'b1, 8'($urandom));
            else if (r < 130) send(8'($urandom));
            else              idle(1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/upg_loader.md
Name: upg_loader

Overview:
- UART programming sequencer that drives the upg_* programming port of the instruction and data memories.
- Assembles bytes from the UART receiver into little-endian 32-bit words and issues one-cycle write strobes to sequential word addresses.
- Fills the whole instruction memory first, then the whole data memory, then asserts upg_done_o so the CPU returns to normal mode.
- Sits between the UART byte receiver and both memory wrappers. busy_o acts as the inverse of the memories' normal-mode select.

Parameters:
- ADDR_W, 14, word-address width of each memory.
- WORDS, 16384, words loaded per memory (at most 2^ADDR_W).
- TIMEOUT, 10000000, idle clock cycles allowed between bytes mid-session before abort.
- TO_W, 24, width of the timeout counter (2^TO_W > TIMEOUT).

Ports:
- clock in 1: single clock, all logic rising edge.
- rst_n in 1: asynchronous active-low reset.
- start_i in 1: one-cycle pulse that begins a programming session.
- abort_i in 1: synchronous abort of the current session.
- rx_valid_i in 1: one-cycle strobe, a received byte is present.
- rx_data_i in 8: received byte.
- upg_wen_o out 1: memory write strobe, one cycle per word.
- upg_adr_o out ADDR_W+1: bit ADDR_W selects the memory (0 = imem, 1 = dmem); low bits are the word address.
- upg_dat_o out 32: write data.
- upg_done_o out 1: image fully written.
- busy_o out 1: session in progress; memories must be in programming mode.
- err_o out 1: last session ended by timeout or abort.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, busy_o=0, err_o=0.
  - Byte lane counter=0, word counter=0, timeout counter=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE / DONE:
  - start_i=1 → RECV next cycle.
  - On entry to RECV: busy_o=1, upg_done_o=0, err_o=0, lane=0, word counter=0, timeout=0.
  - rx_valid_i is ignored in IDLE and DONE, including in the start_i cycle.
  - DONE holds upg_done_o=1 until the next start_i or reset.
- RECV:
  - Each rx_valid_i writes rx_data_i into byte lane `lane` of the assembly register (lane 0 = bits 7:0), increments lane, and clears the timeout counter.
  - When the byte for lane 3 arrives: the assembled word is copied to upg_dat_o, upg_adr_o={mem_sel, word_idx}, and state → WRITE.
- WRITE:
  - Exactly one cycle with upg_wen_o=1; upg_adr_o and upg_dat_o are stable during it and hold until the next word.
  - Then the word counter increments.
  - If the counter reaches 2*WORDS: → DONE, upg_done_o=1, busy_o=0.
  - Otherwise → RECV.
  - A byte arriving in the WRITE cycle is accepted into lane 0 of the next word (the assembly register is separate from upg_dat_o), so no byte is lost.
- Address mapping:
  - Words 0..WORDS-1 map to imem addresses 0..WORDS-1 (mem_sel=0).
  - Words WORDS..2*WORDS-1 map to dmem addresses 0..WORDS-1 (mem_sel=1).
  - The word index wraps to 0 exactly at the imem→dmem boundary.
- Timeout:
  - The timeout counter runs in RECV only.
  - When it reaches TIMEOUT-1 with no byte: → IDLE, err_o=1, busy_o=0, upg_done_o=0. The partial word is discarded; no write is issued.
  - A byte arriving in the same cycle as expiry wins: it is accepted and the counter clears.
- abort_i:
  - In RECV or WRITE: → IDLE next cycle, err_o=1, busy_o=0, upg_wen_o forced 0 that cycle.
  - abort_i has priority over start_i, rx_valid_i and timeout.
  - In IDLE or DONE, abort_i has no effect.
- start_i while busy is ignored.
- Mid-session reset clears everything; the memory contents already written are not rolled back.
- Timeout counter width is TO_W; arithmetic is unsigned and must not overflow, since it is cleared on expiry.

Test Plan:
- WORDS=2: reset, start, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE, then eight more → writes in order:
  - adr 0x0000 dat 0x12345678
  - adr 0x0001 dat 0xDEADBEEF
  - adr 0x4000, then adr 0x4001
  - each with a single-cycle upg_wen_o
  - then upg_done_o=1, busy_o=0.
- Back-to-back bytes every cycle including the WRITE cycle → no byte dropped; the second word is assembled correctly.
- 3 bytes, then idle for TIMEOUT cycles (TIMEOUT=16) → no upg_wen_o, err_o=1, state IDLE; a later start clears err_o.
- abort_i asserted in the same cycle as the 4th byte → no write, err_o=1, busy_o=0.
- start_i and rx_valid_i in the same cycle in IDLE → byte ignored; the first written word comes from the next 4 bytes only.
- rst_n low mid-session (after 5 bytes) → all outputs 0 immediately (asynchronous); start_i after release restarts at adr 0.
